// File: rtl/cmd_pkg.sv
// Shared opcode constants, opcode field placement and dispatcher state
// encoding for the command dispatcher and its per-core FIFOs.
package cmd_pkg;

    localparam int OPC_W = 8;

    localparam logic [OPC_W-1:0] OPC_HALT  = 8'h00;
    localparam logic [OPC_W-1:0] OPC_FENCE = 8'h01;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FENCE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } disp_state_e;

    // The opcode always occupies the top OPC_W bits of a command.
    function automatic int opc_lsb(input int cmd_w);
        return cmd_w - OPC_W;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Per-core command FIFO with wrap-bit pointers; head is the oldest entry
// and is valid whenever empty is low.
module cmd_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/cmd_dispatcher.sv
// Routes host commands into per-core FIFOs and issues start pulses to idle
// cores, with FENCE barrier, draining HALT and bad-core-id reporting.
module cmd_dispatcher
    import cmd_pkg::*;
#(
    parameter int NUM_CORES   = 4,
    parameter int CORE_ID_W   = 2,
    parameter int CORE_ID_LSB = 48,
    parameter int FIFO_DEPTH  = 4,
    parameter int CMD_W       = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    input  logic [CMD_W-1:0]           cmd_data,
    output logic                       cmd_ready,
    input  logic [NUM_CORES-1:0]       core_ready,
    output logic [NUM_CORES-1:0]       core_start,
    output logic [NUM_CORES*CMD_W-1:0] core_cmd,
    output logic                       halted,
    output logic                       fence_busy,
    output logic                       err_bad_core
);

    localparam int OPC_LSB = opc_lsb(CMD_W);
    localparam logic [CORE_ID_W:0] NUM_CORES_L = (CORE_ID_W+1)'(NUM_CORES);

    disp_state_e state;

    logic [OPC_W-1:0]     opcode;
    logic [CORE_ID_W-1:0] core_id;
    logic                 is_halt;
    logic                 is_fence;
    logic                 is_work;
    logic                 bad_id;
    logic                 id_full;
    logic                 accept;
    logic                 all_idle;

    logic [NUM_CORES-1:0] fifo_full;
    logic [NUM_CORES-1:0] fifo_empty;
    logic [NUM_CORES-1:0] fifo_push;
    logic [NUM_CORES-1:0] fifo_pop;
    logic [NUM_CORES-1:0] start_q;
    logic [CMD_W-1:0]     fifo_head [NUM_CORES];

    assign opcode   = cmd_data[OPC_LSB +: OPC_W];
    assign core_id  = cmd_data[CORE_ID_LSB +: CORE_ID_W];
    assign is_halt  = (opcode == OPC_HALT);
    assign is_fence = (opcode == OPC_FENCE);
    assign is_work  = !is_halt && !is_fence;
    assign bad_id   = ({1'b0, core_id} >= NUM_CORES_L);

    // Full flag of the addressed FIFO; ids past NUM_CORES never block.
    always_comb begin
        id_full = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (core_id == CORE_ID_W'(i))
                id_full = fifo_full[i];
        end
    end

    assign cmd_ready = !rst && (state == ST_RUN) &&
                       (is_halt || is_fence || bad_id || !id_full);
    assign accept    = cmd_valid && cmd_ready;
    assign all_idle  = (&fifo_empty) && !(|start_q) && (&core_ready);

    // A start is masked during reset so no pulse escapes the reset cycle.
    assign core_start = start_q & {NUM_CORES{!rst}};

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        assign fifo_push[g] = accept && is_work && !bad_id && (core_id == CORE_ID_W'(g));
        assign fifo_pop[g]  = !fifo_empty[g] && core_ready[g] && !start_q[g] &&
                              (state != ST_HALTED);

        cmd_fifo #(
            .DATA_W (CMD_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (fifo_push[g]),
            .push_data (cmd_data),
            .pop       (fifo_pop[g]),
            .full      (fifo_full[g]),
            .empty     (fifo_empty[g]),
            .head      (fifo_head[g])
        );
    end

    // Start pulse and payload register; a high start_q also provides the
    // one-cycle holdoff before the same core can be popped again.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q  <= '0;
            core_cmd <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                start_q[i] <= fifo_pop[i];
                if (fifo_pop[i])
                    core_cmd[i*CMD_W +: CMD_W] <= fifo_head[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            halted       <= 1'b0;
            fence_busy   <= 1'b0;
            err_bad_core <= 1'b0;
        end else begin
            err_bad_core <= accept && is_work && bad_id;
            case (state)
                ST_RUN: begin
                    if (accept && is_fence) begin
                        state      <= ST_FENCE;
                        fence_busy <= 1'b1;
                    end else if (accept && is_halt) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_FENCE: begin
                    if (all_idle) begin
                        state      <= ST_RUN;
                        fence_busy <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (all_idle) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_HALTED;
                    halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Randomised and directed bench for cmd_dispatcher (3 cores, 2-bit id field)
// compared every cycle against a queue-based behavioural model.
module tb_cmd_dispatcher;

    localparam int NC  = 3;
    localparam int IDW = 2;
    localparam int LSB = 48;
    localparam int D   = 4;
    localparam int W   = 64;
    localparam int VW  = NC * W;

    typedef logic [W-1:0] cmdq_t [$];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [W-1:0]  cmd_data = '0;
    logic          cmd_ready;
    logic [NC-1:0] core_ready = '1;
    logic [NC-1:0] core_start;
    logic [VW-1:0] core_cmd;
    logic          halted;
    logic          fence_busy;
    logic          err_bad_core;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cmd_dispatcher #(
        .NUM_CORES   (NC),
        .CORE_ID_W   (IDW),
        .CORE_ID_LSB (LSB),
        .FIFO_DEPTH  (D),
        .CMD_W       (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .core_ready   (core_ready),
        .core_start   (core_start),
        .core_cmd     (core_cmd),
        .halted       (halted),
        .fence_busy   (fence_busy),
        .err_bad_core (err_bad_core)
    );

    // Reference model: plain queues per core plus barrier/drain/halt flags.
    cmdq_t         q [NC];
    logic [NC-1:0] m_start;
    logic [W-1:0]  m_cmd [NC];
    bit            m_fence;
    bit            m_drain;
    bit            m_halted;
    bit            m_err;

    function automatic logic [W-1:0] mk(input logic [7:0] op, input logic [1:0] id,
                                        input logic [47:0] pl);
        return {op, 6'b0, id, pl};
    endfunction

    function automatic bit model_ready(input logic r, input logic [W-1:0] d);
        int id;
        id = int'(d[LSB +: IDW]);
        if (r || m_fence || m_drain || m_halted)
            return 1'b0;
        if (d[W-1 -: 8] == 8'h00 || d[W-1 -: 8] == 8'h01 || id >= NC)
            return 1'b1;
        return q[id].size() < D;
    endfunction

    task automatic model_step(input logic r, input bit acc, input logic [W-1:0] d,
                              input logic [NC-1:0] cr);
        bit            idle;
        logic [NC-1:0] ns;
        logic [7:0]    op;
        int            id;
        if (r) begin
            for (int i = 0; i < NC; i++) begin
                q[i].delete();
                m_cmd[i] = '0;
            end
            m_start = '0;
            m_fence = 0; m_drain = 0; m_halted = 0; m_err = 0;
            return;
        end
        idle = (m_start == '0) && (cr == '1);
        for (int i = 0; i < NC; i++)
            if (q[i].size() != 0) idle = 0;
        ns = '0;
        for (int i = 0; i < NC; i++) begin
            if (q[i].size() > 0 && cr[i] && !m_start[i] && !m_halted) begin
                ns[i]    = 1'b1;
                m_cmd[i] = q[i].pop_front();
            end
        end
        m_start = ns;
        op = d[W-1 -: 8];
        id = int'(d[LSB +: IDW]);
        m_err = acc && (op > 8'h01) && (id >= NC);
        if (acc && op > 8'h01 && id < NC)
            q[id].push_back(d);
        if (m_fence) begin
            if (idle) m_fence = 0;
        end else if (m_drain) begin
            if (idle) begin
                m_drain  = 0;
                m_halted = 1;
            end
        end else if (acc && op == 8'h00) begin
            m_drain = 1;
        end else if (acc && op == 8'h01) begin
            m_fence = 1;
        end
    endtask

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock: drive inputs, compare every output with the model, advance it.
    task automatic cycle(input logic r, input logic v, input logic [W-1:0] d,
                         input logic [NC-1:0] cr);
        bit            er;
        logic [VW-1:0] ecmd;
        @(negedge clk);
        rst = r; cmd_valid = v; cmd_data = d; core_ready = cr;
        #1;
        er = model_ready(r, d);
        for (int i = 0; i < NC; i++)
            ecmd[i*W +: W] = m_cmd[i];
        chk("cmd_ready", VW'(cmd_ready), VW'(er));
        chk("core_start", VW'(core_start), VW'(r ? '0 : m_start));
        chk("core_cmd", core_cmd, ecmd);
        chk("halted", VW'(halted), VW'(m_halted));
        chk("fence_busy", VW'(fence_busy), VW'(m_fence));
        chk("err_bad_core", VW'(err_bad_core), VW'(m_err));
        model_step(r, v && er, d, cr);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b0, '0, '1);
    endtask

    logic [W-1:0] c [5];
    logic [W-1:0] d0;
    logic [W-1:0] tmp;
    int           nstart;
    int           last_k;
    int           acc_k;
    bit           done;

    initial begin
        m_start = '0; m_fence = 0; m_drain = 0; m_halted = 0; m_err = 0;
        for (int i = 0; i < NC; i++) m_cmd[i] = '0;

        // 1: reset with valid held high, then one command to core 2
        @(negedge clk);
        rst = 1'b1; cmd_valid = 1'b1; cmd_data = mk(8'h10, 2'd1, 48'h1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, mk(8'h10, 2'd1, 48'h1), '1);
            chk("rst_cmd_ready", VW'(cmd_ready), '0);
            chk("rst_core_start", VW'(core_start), '0);
            chk("rst_halted", VW'(halted), '0);
        end
        d0 = mk(8'h10, 2'd2, 48'hABCD_0123_4567);
        cycle(1'b0, 1'b1, d0, 3'b111);
        chk("t1_accept", VW'(cmd_ready), VW'(1'b1));
        cycle(1'b0, 1'b0, '0, 3'b111);
        chk("t1_no_early_start", VW'(core_start), '0);
        cycle(1'b0, 1'b0, '0, 3'b111);
        chk("t1_start", VW'(core_start), VW'(3'b100));
        chk("t1_payload", VW'(core_cmd[2*W +: W]), VW'(d0));
        idle_cycles(3);

        // 2: backpressure on core 1
        for (int i = 0; i < 5; i++) c[i] = mk(8'h20 + 8'(i), 2'd1, 48'h1000 + 48'(i));
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, c[i], 3'b101);
            chk("t2_fill_ready", VW'(cmd_ready), VW'(i < 4));
        end
        nstart = 0; last_k = -10; acc_k = -1;
        for (int k = 0; k < 30; k++) begin
            cycle(1'b0, acc_k < 0, c[4], 3'b111);
            if (k == 0) chk("t2_full_refuses", VW'(cmd_ready), '0);
            if (acc_k < 0 && cmd_ready) acc_k = k;
            if (core_start[1]) begin
                if (nstart < 5) chk("t2_order", VW'(core_cmd[W +: W]), VW'(c[nstart]));
                chk("t2_spacing", VW'(k - last_k >= 2), VW'(1'b1));
                last_k = k;
                nstart++;
            end
        end
        chk("t2_fifth_after_pop", VW'(acc_k), VW'(1));
        chk("t2_start_count", VW'(nstart), VW'(5));

        // 3: one command each to cores 0..2 on consecutive cycles
        for (int i = 0; i < 3; i++) c[i] = mk(8'h30, 2'(i), 48'h3000 + 48'(i));
        cycle(1'b0, 1'b1, c[0], 3'b111);
        cycle(1'b0, 1'b1, c[1], 3'b111);
        cycle(1'b0, 1'b1, c[2], 3'b111);
        chk("t3_start0", VW'(core_start), VW'(3'b001));
        chk("t3_cmd0", VW'(core_cmd[0 +: W]), VW'(c[0]));
        cycle(1'b0, 1'b0, '0, 3'b111);
        chk("t3_start1", VW'(core_start), VW'(3'b010));
        chk("t3_cmd1", VW'(core_cmd[W +: W]), VW'(c[1]));
        cycle(1'b0, 1'b0, '0, 3'b111);
        chk("t3_start2", VW'(core_start), VW'(3'b100));
        chk("t3_cmds", core_cmd, {c[2], c[1], c[0]});
        idle_cycles(3);

        // 4: FENCE behind two queued commands for a busy core 0
        cycle(1'b0, 1'b1, mk(8'h40, 2'd0, 48'h4000), 3'b110);
        cycle(1'b0, 1'b1, mk(8'h41, 2'd0, 48'h4001), 3'b110);
        cycle(1'b0, 1'b1, mk(8'h01, 2'd0, 48'h0), 3'b110);
        chk("t4_fence_accept", VW'(cmd_ready), VW'(1'b1));
        d0 = mk(8'h42, 2'd1, 48'h4100);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, d0, 3'b110);
            chk("t4_fence_busy", VW'(fence_busy), VW'(1'b1));
            chk("t4_blocked", VW'(cmd_ready), '0);
        end
        nstart = 0; done = 0;
        for (int k = 0; k < 30 && !done; k++) begin
            cycle(1'b0, 1'b1, d0, 3'b111);
            if (core_start[0]) nstart++;
            if (!fence_busy) done = 1;
        end
        chk("t4_fence_cleared", VW'(done), VW'(1'b1));
        chk("t4_after_fence_ready", VW'(cmd_ready), VW'(1'b1));
        chk("t4_starts", VW'(nstart), VW'(2));
        idle_cycles(4);

        // 5: command to non-existent core 3
        cycle(1'b0, 1'b1, mk(8'h50, 2'd3, 48'h5000), 3'b111);
        chk("t5_accept", VW'(cmd_ready), VW'(1'b1));
        cycle(1'b0, 1'b0, '0, 3'b111);
        chk("t5_err_pulse", VW'(err_bad_core), VW'(1'b1));
        cycle(1'b0, 1'b0, '0, 3'b111);
        chk("t5_err_clear", VW'(err_bad_core), '0);
        chk("t5_no_start", VW'(core_start), '0);
        idle_cycles(2);

        // 6a: HALT drains queued work then halts
        cycle(1'b0, 1'b1, mk(8'h60, 2'd2, 48'h6000), 3'b011);
        cycle(1'b0, 1'b1, mk(8'h61, 2'd2, 48'h6001), 3'b011);
        cycle(1'b0, 1'b1, mk(8'h00, 2'd0, 48'h0), 3'b011);
        chk("t6_halt_accept", VW'(cmd_ready), VW'(1'b1));
        nstart = 0; done = 0;
        for (int k = 0; k < 30 && !done; k++) begin
            cycle(1'b0, 1'b0, '0, 3'b111);
            if (core_start[2]) nstart++;
            if (halted) done = 1;
        end
        chk("t6_halted", VW'(done), VW'(1'b1));
        chk("t6_drained", VW'(nstart), VW'(2));
        cycle(1'b0, 1'b1, mk(8'h62, 2'd0, 48'h6002), 3'b111);
        chk("t6_refused", VW'(cmd_ready), '0);
        chk("t6_sticky", VW'(halted), VW'(1'b1));

        // 6b: reset in the middle of a drain
        cycle(1'b1, 1'b0, '0, 3'b111);
        cycle(1'b1, 1'b0, '0, 3'b111);
        cycle(1'b0, 1'b1, mk(8'h63, 2'd0, 48'h6003), 3'b110);
        cycle(1'b0, 1'b1, mk(8'h64, 2'd0, 48'h6004), 3'b110);
        cycle(1'b0, 1'b1, mk(8'h00, 2'd0, 48'h0), 3'b110);
        cycle(1'b0, 1'b0, '0, 3'b111);
        cycle(1'b1, 1'b0, '0, 3'b111);
        chk("t6_rst_start_masked", VW'(core_start), '0);
        cycle(1'b1, 1'b0, '0, 3'b111);
        nstart = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 1'b0, '0, 3'b111);
            if (core_start != '0) nstart++;
        end
        chk("t6_no_starts_after_rst", VW'(nstart), '0);
        chk("t6_not_halted", VW'(halted), '0);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            logic          r;
            logic          v;
            logic [7:0]    op;
            logic [NC-1:0] cr;
            int            sel;
            r   = ($urandom_range(0, 299) == 0) || (m_halted && $urandom_range(0, 15) == 0);
            v   = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 63);
            if (sel == 0)      op = 8'h00;
            else if (sel < 3)  op = 8'h01;
            else               op = 8'(8'h02 + 8'($urandom_range(0, 253)));
            tmp = {$urandom(), $urandom()};
            tmp[W-1 -: 8] = op;
            tmp[LSB +: IDW] = 2'($urandom_range(0, 3));
            for (int i = 0; i < NC; i++) cr[i] = ($urandom_range(0, 3) != 0);
            cycle(r, v, tmp, cr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_dispatcher.md
Name: cmd_dispatcher

Overview:
- Parametrised multi-core command dispatcher placed between the host command stream and NUM_CORES compute cores.
- Decodes a per-command core-select field and buffers each command in a per-core FIFO.
- Issues single-cycle start pulses with the command payload to each core as that core becomes ready.
- Adds FENCE (barrier) and draining HALT semantics, and flags commands addressed to a non-existent core.

Parameters:
- NUM_CORES, 4, number of target cores (1..2**CORE_ID_W).
- CORE_ID_W, 2, width of the core-select field.
- CORE_ID_LSB, 48, bit position of the core-select field LSB within a command.
- FIFO_DEPTH, 4, entries per per-core FIFO (power of two, at least 2).
- CMD_W, 64, command width; opcode is always cmd_data[CMD_W-1 -: 8].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  host command valid
- cmd_data  in  CMD_W  host command
- cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready
- core_ready  in  NUM_CORES  per-core idle/ready
- core_start  out  NUM_CORES  one-cycle start pulse per core
- core_cmd  out  NUM_CORES*CMD_W  per-core payload; slice i is valid while core_start[i] is high and holds its value until the next start to that core
- halted  out  1  dispatcher halted (sticky until rst)
- fence_busy  out  1  high while a FENCE is waiting
- err_bad_core  out  1  one-cycle pulse: a command was dropped because its core id was >= NUM_CORES

Behaviour:
- Reset (synchronous, active-high; clk rising edge): state=RUN, FIFOs empty, core_start=0, core_cmd=0, halted=0, fence_busy=0, err_bad_core=0, cmd_ready=0 while rst is high.
- Opcodes:
  - 0x00 HALT.
  - 0x01 FENCE.
  - Any other value is a work command. The core id is cmd_data[CORE_ID_LSB +: CORE_ID_W].
- cmd_ready (combinational) = !rst && state==RUN && (opcode is HALT, or opcode is FENCE, or id >= NUM_CORES, or the FIFO[id] not-full flag as registered at the start of the cycle).
  - A full FIFO never accepts a command, even if it pops in the same cycle.
- Work command accepted: it is pushed into FIFO[id] in the same cycle. The command is visible at the FIFO head on the next cycle.
- Bad id: the command is accepted and dropped; err_bad_core pulses on the following cycle.
- Dispatch, per core i, independent across cores:
  - When FIFO[i] is non-empty, core_ready[i]=1 and core_start[i] was 0 in the previous cycle, pop the head.
  - Register core_start[i]=1 and core_cmd slice i = head on the next edge.
  - Minimum latency from acceptance to start: 2 cycles.
  - After a start, core i gets a mandatory 1-cycle holdoff so the core can drop core_ready. Back-to-back starts to the same core are at least 2 cycles apart.
- States:
  - RUN: normal operation. FENCE accepted -> FENCE. HALT accepted -> DRAIN.
  - FENCE: fence_busy=1, cmd_ready=0, dispatch continues. Leave to RUN on the cycle after all FIFOs are empty, no start pulse is high and all core_ready bits are 1.
  - DRAIN: cmd_ready=0, dispatch continues. Leave to HALTED when the same all-idle condition holds.
  - HALTED: halted=1, cmd_ready=0, no further starts. Exit only via rst.
- Reset mid-operation: FIFO contents are discarded, and any start pulse is suppressed from the reset cycle onward.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. full = (MSBs differ && rest equal); empty = pointers equal.
- Simultaneous push and pop on the same FIFO: both take effect and the count is unchanged.

Decomposition:
- Package cmd_pkg holds:
  - OPC_HALT=8'h00 and OPC_FENCE=8'h01.
  - The opcode field position.
  - A dispatcher state enum {RUN, FENCE, DRAIN, HALTED}.
- One sub-module, cmd_fifo (width CMD_W, depth FIFO_DEPTH; push/pop/full/empty/head), instantiated NUM_CORES times via generate.

Test Plan:
1. Reset then idle: rst=1 for 3 cycles with cmd_valid=1 -> cmd_ready=0, core_start=0, halted=0. After reset, a work command to core 2 (opcode 0x10) with core_ready=4'hF -> core_start=4'b0100 exactly 2 cycles later, and core_cmd slice 2 equals the command.
2. Backpressure: core_ready[1]=0, then send 5 commands to core 1 with FIFO_DEPTH=4 -> 4 are accepted and cmd_ready=0 for the 5th. Raise core_ready[1] -> starts occur in order, at least 2 cycles apart, and the 5th command is accepted after the first pop.
3. Parallel cores: one command each to cores 0..3 on consecutive cycles, all ready -> four starts, each 2 cycles after its own acceptance, with correct payloads and no cross-talk between slices.
4. FENCE: FIFO0 holds 2 commands and core 0 is busy, then send FENCE -> fence_busy=1 and cmd_ready=0 until both commands have started and core_ready=4'hF. fence_busy then drops and the next command is accepted.
5. Bad id with NUM_CORES=3: command to id 3 -> accepted, err_bad_core pulses for 1 cycle, no core_start.
6. HALT drain plus reset: queue 2 commands, send HALT -> both dispatched, halted=1, later commands are refused. Assert rst mid-drain in a second run -> no starts after the reset edge and FIFOs are empty.
